// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART boot loader.
// The CHECK state is always declared; it is only reachable when the
// design is built with LOADER_CHECKSUM_EN.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    SEND_START,
    RECV_SIZE,
    RECV_DATA,
    CHECK,
    SEND_DONE,
    RUN,
    ERROR
  } boot_state_t;

  localparam logic [7:0] BOOT_START_BYTE = 8'h99;
  localparam logic [7:0] BOOT_DONE_BYTE  = 8'hAA;
  localparam logic [7:0] BOOT_NAK_BYTE   = 8'hEE;

  // Place a byte into one lane of a little-endian 32-bit word.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  data);
    logic [31:0] result;
    result = word;
    result[8*lane +: 8] = data;
    return result;
  endfunction

endpackage

// File: rtl/uart_boot_loader_tx_issuer.sv
// Single-shot byte sender in front of UART_TX.
// A request is taken only while idle: UART_TX not busy, no strobe in
// flight and the guard cycle over. The guard covers the cycle after a
// strobe, before UART_TX has had a chance to raise tx_busy.
// Handshake: req is a level; a byte is issued in the cycle where
// req && idle, and the requester must treat that cycle as "accepted".
module uart_tx_issuer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       req,
  input  logic [7:0] req_byte,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_sdata,
  output logic       idle
);

  logic guard;

  assign idle = !tx_busy && !guard && !tx_start;

  // One-cycle strobe with the byte latched, followed by one guard cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_start <= 1'b0;
      tx_sdata <= 8'h00;
      guard    <= 1'b0;
    end else begin
      guard    <= tx_start;
      tx_start <= req && idle;
      if (req && idle) begin
        tx_sdata <= req_byte;
      end
    end
  end

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot sequencer: announces itself with 0x99, receives a 4-byte
// little-endian program size and the program, writes it to instruction
// memory as 32-bit little-endian words, answers 0xAA and then releases
// the CPU and hands the UART pair over to it.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte; a mismatch is answered with 0xEE and ends in ERROR.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int IMEM_ADDR_WIDTH   = 15,
  parameter int MAX_PROGRAM_BYTES = 131072
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [7:0]                 rx_rdata,
  input  logic                       rx_rdata_ready,
  input  logic                       rx_ferr,
  output logic [7:0]                 tx_sdata,
  output logic                       tx_start,
  input  logic                       tx_busy,
  output logic                       imem_we,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic                       cpu_reset_n,
  output logic                       boot_done,
  output logic                       boot_error,
  input  logic [7:0]                 cpu_tx_sdata,
  input  logic                       cpu_tx_start,
  output logic                       cpu_tx_busy,
  output logic                       cpu_rx_rdata_ready
);

  boot_state_t state;
  logic [1:0]  size_cnt;
  logic [31:0] size;
  logic [31:0] byte_cnt;
  logic [31:0] word_buf;
  logic        data_last;
  logic        tx_sent;

  logic        send_req;
  logic [7:0]  send_byte;
  logic        iss_start;
  logic [7:0]  iss_sdata;
  logic        iss_idle;
  logic [31:0] size_full;
  logic [31:0] lane_word;
  logic        last_byte;
  boot_state_t post_data;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  csum;
  logic        nak_pend;
  assign post_data = CHECK;
`else
  assign post_data = SEND_DONE;
`endif

  uart_tx_issuer u_issuer (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (send_req),
    .req_byte (send_byte),
    .tx_busy  (tx_busy),
    .tx_start (iss_start),
    .tx_sdata (iss_sdata),
    .idle     (iss_idle)
  );

  // After boot the core owns the UART; boot_done is high exactly in RUN.
  assign tx_start           = boot_done ? cpu_tx_start : iss_start;
  assign tx_sdata           = boot_done ? cpu_tx_sdata : iss_sdata;
  assign cpu_tx_busy        = boot_done ? tx_busy : 1'b1;
  assign cpu_rx_rdata_ready = boot_done & rx_rdata_ready;

  // Which byte the loader wants to send in the current state, if any.
  always_comb begin
    send_req  = 1'b0;
    send_byte = BOOT_START_BYTE;
    case (state)
      SEND_START: send_req = !rx_ferr;
      SEND_DONE: begin
        send_req  = !tx_sent && !rx_ferr;
        send_byte = BOOT_DONE_BYTE;
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        send_req  = nak_pend && !rx_ferr;
        send_byte = BOOT_NAK_BYTE;
      end
`endif
      default: send_req = 1'b0;
    endcase
  end

  // Datapath helpers: completed size word, word with the incoming byte merged
  // into its lane, and whether the incoming byte is the final program byte.
  always_comb begin
    size_full = {rx_rdata, size[23:0]};
    lane_word = merge_lane(word_buf, byte_cnt[1:0], rx_rdata);
    last_byte = (byte_cnt + 32'd1) == size;
  end

  // Boot sequencer FSM with registered memory-write and status outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= SEND_START;
      size_cnt    <= 2'd0;
      size        <= 32'd0;
      byte_cnt    <= 32'd0;
      word_buf    <= 32'd0;
      data_last   <= 1'b0;
      tx_sent     <= 1'b0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= 32'd0;
      cpu_reset_n <= 1'b0;
      boot_done   <= 1'b0;
      boot_error  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum        <= 8'h00;
      nak_pend    <= 1'b0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (rx_ferr && state != RUN && state != ERROR) begin
        state       <= ERROR;
        boot_error  <= 1'b1;
        cpu_reset_n <= 1'b0;
      end else begin
        case (state)
          SEND_START: begin
            if (iss_idle) begin
              state <= RECV_SIZE;
            end
          end
          RECV_SIZE: begin
            if (rx_rdata_ready) begin
              size[8*size_cnt +: 8] <= rx_rdata;
              size_cnt              <= size_cnt + 2'd1;
              if (size_cnt == 2'd3) begin
                if (size_full == 32'd0) begin
                  state <= post_data;
                end else if (size_full > 32'(MAX_PROGRAM_BYTES)) begin
                  state       <= ERROR;
                  boot_error  <= 1'b1;
                  cpu_reset_n <= 1'b0;
                end else begin
                  state <= RECV_DATA;
                end
              end
            end
          end
          RECV_DATA: begin
            if (data_last) begin
              // The final word write is on imem_we during this cycle.
              data_last <= 1'b0;
              state     <= post_data;
            end else if (rx_rdata_ready) begin
              byte_cnt <= byte_cnt + 32'd1;
`ifdef LOADER_CHECKSUM_EN
              csum     <= csum ^ rx_rdata;
`endif
              if (byte_cnt[1:0] == 2'd3 || last_byte) begin
                imem_we    <= 1'b1;
                imem_addr  <= byte_cnt[IMEM_ADDR_WIDTH+1:2];
                imem_wdata <= lane_word;
                word_buf   <= 32'd0;
              end else begin
                word_buf <= lane_word;
              end
              if (last_byte) begin
                data_last <= 1'b1;
              end
            end
          end
`ifdef LOADER_CHECKSUM_EN
          CHECK: begin
            if (nak_pend) begin
              if (iss_idle) begin
                nak_pend    <= 1'b0;
                state       <= ERROR;
                boot_error  <= 1'b1;
                cpu_reset_n <= 1'b0;
              end
            end else if (rx_rdata_ready) begin
              if (rx_rdata == csum) begin
                state <= SEND_DONE;
              end else begin
                nak_pend <= 1'b1;
              end
            end
          end
`endif
          SEND_DONE: begin
            if (!tx_sent) begin
              if (iss_idle) begin
                tx_sent <= 1'b1;
              end
            end else if (iss_idle) begin
              state       <= RUN;
              boot_done   <= 1'b1;
              cpu_reset_n <= 1'b1;
            end
          end
          default: begin
            // RUN and ERROR hold until reset.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule
